// File: rtl/mem_wb_skid_reg.sv
// Elastic MEM->WB pipeline register with a 2-entry skid buffer (head H + skid S),
// flush, write-back value mux, occupancy report and a saturating stall counter.
module mem_wb_skid_reg #(
    parameter int DATA_W = 32,
    parameter int DEST_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              wb_en_in,
    input  logic              mem_r_en_in,
    input  logic [DATA_W-1:0] alu_result_in,
    input  logic [DATA_W-1:0] data_memory_out_in,
    input  logic [DEST_W-1:0] dest_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              wb_en,
    output logic              mem_r_en,
    output logic [DATA_W-1:0] alu_result,
    output logic [DATA_W-1:0] data_memory_out,
    output logic [DEST_W-1:0] dest,
    output logic [DATA_W-1:0] wb_value,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Beat layout, MSB first: wb_en, mem_r_en, alu_result, data_memory_out, dest
    localparam int BEAT_W  = 2 + 2 * DATA_W + DEST_W;
    localparam int ALU_HI  = DEST_W + 2 * DATA_W - 1;
    localparam int DMEM_HI = DEST_W + DATA_W - 1;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic              in_ready_r;
    logic [BEAT_W-1:0] head_r;
    logic [BEAT_W-1:0] skid_r;
    logic [BEAT_W-1:0] beat_in_s;
    logic [CNT_W-1:0]  stall_cnt_r;
    logic              accept_s;
    logic              pop_s;
    logic              out_valid_s;
    logic              mem_r_en_s;
    logic              load_h_s;
    logic              load_s_s;
    logic              move_s_s;

    assign beat_in_s   = {wb_en_in, mem_r_en_in, alu_result_in, data_memory_out_in, dest_in};
    assign out_valid_s = (state_r != ST_EMPTY);
    assign accept_s    = in_valid & in_ready_r;
    assign pop_s       = out_valid_s & out_ready;

    // Next-state and register-load selection; flush wins over accept and pop
    always_comb begin
        state_nxt_s = state_r;
        load_h_s    = 1'b0;
        load_s_s    = 1'b0;
        move_s_s    = 1'b0;
        if (flush) begin
            state_nxt_s = ST_EMPTY;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s) begin
                        load_h_s    = 1'b1;
                        state_nxt_s = ST_ONE;
                    end else begin
                        state_nxt_s = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (accept_s && pop_s) begin
                        load_h_s    = 1'b1;
                        state_nxt_s = ST_ONE;
                    end else if (accept_s) begin
                        load_s_s    = 1'b1;
                        state_nxt_s = ST_FULL;
                    end else if (pop_s) begin
                        state_nxt_s = ST_EMPTY;
                    end else begin
                        state_nxt_s = ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (pop_s) begin
                        move_s_s    = 1'b1;
                        state_nxt_s = ST_ONE;
                    end else begin
                        state_nxt_s = ST_FULL;
                    end
                end
                default: begin
                    state_nxt_s = ST_EMPTY;
                end
            endcase
        end
    end

    // State register and registered in_ready
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r    <= ST_EMPTY;
            in_ready_r <= 1'b1;
        end else begin
            state_r    <= state_nxt_s;
            in_ready_r <= (state_nxt_s != ST_FULL);
        end
    end

    // Head and skid data registers, loaded only on their own load events
    always_ff @(posedge clk) begin
        if (!rst) begin
            head_r <= {BEAT_W{1'b0}};
            skid_r <= {BEAT_W{1'b0}};
        end else begin
            if (load_h_s) begin
                head_r <= beat_in_s;
            end else if (move_s_s) begin
                head_r <= skid_r;
            end else begin
                head_r <= head_r;
            end
            if (load_s_s) begin
                skid_r <= beat_in_s;
            end else begin
                skid_r <= skid_r;
            end
        end
    end

    // Saturating back-pressure counter; only reset clears it
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (out_valid_s && !out_ready && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    // Occupancy decode from the buffer state
    always_comb begin
        occupancy = 2'd0;
        case (state_r)
            ST_EMPTY: occupancy = 2'd0;
            ST_ONE:   occupancy = 2'd1;
            ST_FULL:  occupancy = 2'd2;
            default:  occupancy = 2'd0;
        endcase
    end

    assign mem_r_en_s      = head_r[BEAT_W-2] & out_valid_s;
    assign in_ready        = in_ready_r;
    assign out_valid       = out_valid_s;
    assign wb_en           = head_r[BEAT_W-1] & out_valid_s;
    assign mem_r_en        = mem_r_en_s;
    assign alu_result      = head_r[ALU_HI -: DATA_W];
    assign data_memory_out = head_r[DMEM_HI -: DATA_W];
    assign dest            = out_valid_s ? head_r[DEST_W-1:0] : {DEST_W{1'b0}};
    assign wb_value        = mem_r_en_s ? head_r[DMEM_HI -: DATA_W] : head_r[ALU_HI -: DATA_W];
    assign stall_cnt       = stall_cnt_r;

endmodule

// File: tb/tb_mem_wb_skid_reg.sv
// Scoreboard bench for mem_wb_skid_reg: directed beats are queued as they are issued,
// a negedge monitor pops and compares every beat the WB side consumes.
module tb_mem_wb_skid_reg;

    typedef struct {
        logic        wb_en;
        logic        mem;
        logic [31:0] alu;
        logic [31:0] dmem;
        logic [3:0]  dest;
        logic [31:0] wbv;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic        wb_en_in;
    logic        mem_r_en_in;
    logic [31:0] alu_result_in;
    logic [31:0] data_memory_out_in;
    logic [3:0]  dest_in;
    logic        out_valid;
    logic        out_ready;
    logic        wb_en;
    logic        mem_r_en;
    logic [31:0] alu_result;
    logic [31:0] data_memory_out;
    logic [3:0]  dest;
    logic [31:0] wb_value;
    logic [1:0]  occupancy;
    logic [15:0] stall_cnt;

    logic        sat_valid;
    logic        sat_ready;
    logic        sat_flush;
    logic        sat_in_ready;
    logic        sat_out_valid;
    logic        sat_wb_en;
    logic        sat_mem_r_en;
    logic [31:0] sat_alu;
    logic [31:0] sat_dmem;
    logic [3:0]  sat_dest;
    logic [31:0] sat_wbv;
    logic [1:0]  sat_occ;
    logic [3:0]  sat_stall;

    beat_t sb[$];
    int    n_vec  = 0;
    int    n_bad  = 0;
    int    n_pops = 0;

    always #5 clk = ~clk;

    mem_wb_skid_reg #(.DATA_W(32), .DEST_W(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .alu_result_in(alu_result_in),
        .data_memory_out_in(data_memory_out_in), .dest_in(dest_in),
        .out_valid(out_valid), .out_ready(out_ready), .wb_en(wb_en), .mem_r_en(mem_r_en),
        .alu_result(alu_result), .data_memory_out(data_memory_out), .dest(dest),
        .wb_value(wb_value), .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    mem_wb_skid_reg #(.DATA_W(32), .DEST_W(4), .CNT_W(4)) u_sat (
        .clk(clk), .rst(rst), .flush(sat_flush), .in_valid(sat_valid), .in_ready(sat_in_ready),
        .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .alu_result_in(alu_result_in),
        .data_memory_out_in(data_memory_out_in), .dest_in(dest_in),
        .out_valid(sat_out_valid), .out_ready(sat_ready), .wb_en(sat_wb_en), .mem_r_en(sat_mem_r_en),
        .alu_result(sat_alu), .data_memory_out(sat_dmem), .dest(sat_dest),
        .wb_value(sat_wbv), .occupancy(sat_occ), .stall_cnt(sat_stall)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic mr, input logic [31:0] alu,
                         input logic [31:0] dm, input logic [3:0] d);
        in_valid           = 1'b1;
        wb_en_in           = we;
        mem_r_en_in        = mr;
        alu_result_in      = alu;
        data_memory_out_in = dm;
        dest_in            = d;
    endtask

    task automatic push(input logic we, input logic mr, input logic [31:0] alu,
                        input logic [31:0] dm, input logic [3:0] d, input logic [31:0] wbv);
        beat_t b;
        b.wb_en = we; b.mem = mr; b.alu = alu; b.dmem = dm; b.dest = d; b.wbv = wbv;
        sb.push_back(b);
    endtask

    // Monitor: a beat is consumed at the next posedge when valid && ready, with no reset or flush
    always @(negedge clk) begin
        if (rst === 1'b1 && flush === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            n_vec++;
            n_pops++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_beat: got alu=0x%0h, expected no beat", alu_result);
            end else begin
                beat_t e;
                e = sb.pop_front();
                if (wb_en !== e.wb_en || mem_r_en !== e.mem || alu_result !== e.alu ||
                    data_memory_out !== e.dmem || dest !== e.dest || wb_value !== e.wbv) begin
                    n_bad++;
                    $display("FAIL beat: got we=%b mr=%b alu=0x%0h dm=0x%0h d=%0d wbv=0x%0h, expected we=%b mr=%b alu=0x%0h dm=0x%0h d=%0d wbv=0x%0h",
                             wb_en, mem_r_en, alu_result, data_memory_out, dest, wb_value,
                             e.wb_en, e.mem, e.alu, e.dmem, e.dest, e.wbv);
                end
            end
        end
    end

    initial begin
        rst = 1'b0; flush = 1'b0; out_ready = 1'b0;
        sat_valid = 1'b0; sat_ready = 1'b0; sat_flush = 1'b0;
        drive(1'b1, 1'b1, 32'hAAAA_5555, 32'h1234_5678, 4'd9);

        // Reset held two edges with in_valid high
        repeat (2) tick();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_wb_en", {31'd0, wb_en}, 32'd0);
        chk("rst_mem_r_en", {31'd0, mem_r_en}, 32'd0);
        chk("rst_alu", alu_result, 32'd0);
        chk("rst_dmem", data_memory_out, 32'd0);
        chk("rst_wb_value", wb_value, 32'd0);
        chk("rst_dest", {28'd0, dest}, 32'd0);
        chk("rst_occ", {30'd0, occupancy}, 32'd0);
        chk("rst_stall", {16'd0, stall_cnt}, 32'd0);
        rst = 1'b1; in_valid = 1'b0;
        tick();
        chk("post_rst_out_valid", {31'd0, out_valid}, 32'd0);

        // Streaming: 8 back-to-back beats, 1-cycle latency
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 1'b0, i, 32'h100 + i, i[3:0]);
            push(1'b1, 1'b0, i, 32'h100 + i, i[3:0], i);
            tick();
            chk("stream_valid", {31'd0, out_valid}, 32'd1);
            chk("stream_alu", alu_result, i);
            chk("stream_occ", {30'd0, occupancy}, 32'd1);
            chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
        end
        in_valid = 1'b0;
        tick();
        chk("stream_drain", {31'd0, out_valid}, 32'd0);

        // Stall/skid: A then B with WB stalled
        out_ready = 1'b0;
        drive(1'b1, 1'b0, 32'h11, 32'h0, 4'd1);
        push(1'b1, 1'b0, 32'h11, 32'h0, 4'd1, 32'h11);
        tick();
        chk("skid_occ1", {30'd0, occupancy}, 32'd1);
        drive(1'b0, 1'b0, 32'h22, 32'h0, 4'd2);
        push(1'b0, 1'b0, 32'h22, 32'h0, 4'd2, 32'h22);
        tick();
        chk("skid_occ2", {30'd0, occupancy}, 32'd2);
        chk("skid_in_ready", {31'd0, in_ready}, 32'd0);
        drive(1'b1, 1'b0, 32'h33, 32'h0, 4'd3);
        repeat (4) tick();
        chk("skid_stall5", {16'd0, stall_cnt}, 32'd5);
        chk("skid_head_a", alu_result, 32'h11);
        chk("skid_full_hold", {30'd0, occupancy}, 32'd2);
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        chk("skid_head_b", alu_result, 32'h22);
        chk("skid_in_ready_back", {31'd0, in_ready}, 32'd1);
        tick();
        chk("skid_empty", {31'd0, out_valid}, 32'd0);
        chk("skid_stall_kept", {16'd0, stall_cnt}, 32'd5);

        // Flush while FULL with an incoming beat; none of these beats may appear
        out_ready = 1'b0;
        drive(1'b1, 1'b0, 32'h44, 32'h0, 4'd4);
        tick();
        drive(1'b1, 1'b0, 32'h55, 32'h0, 4'd5);
        tick();
        chk("flush_pre_occ", {30'd0, occupancy}, 32'd2);
        drive(1'b1, 1'b0, 32'h66, 32'h0, 4'd6);
        flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_occ", {30'd0, occupancy}, 32'd0);
        chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
        chk("flush_stall_kept", {16'd0, stall_cnt}, 32'd7);
        out_ready = 1'b1;
        repeat (2) tick();
        chk("flush_no_ghost", {31'd0, out_valid}, 32'd0);

        // Load mux
        out_ready = 1'b0;
        drive(1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 4'd5);
        push(1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 4'd5, 32'hDEAD_BEEF);
        tick();
        chk("mux_load", wb_value, 32'hDEAD_BEEF);
        chk("mux_load_mr", {31'd0, mem_r_en}, 32'd1);
        out_ready = 1'b1;
        drive(1'b1, 1'b0, 32'h100, 32'hDEAD_BEEF, 4'd6);
        push(1'b1, 1'b0, 32'h100, 32'hDEAD_BEEF, 4'd6, 32'h100);
        tick();
        chk("mux_alu", wb_value, 32'h100);
        in_valid = 1'b0;
        tick();
        chk("mask_wb_en", {31'd0, wb_en}, 32'd0);
        chk("mask_dest", {28'd0, dest}, 32'd0);
        chk("mask_mem_r_en", {31'd0, mem_r_en}, 32'd0);
        chk("mux_stall_total", {16'd0, stall_cnt}, 32'd7);

        // Saturation on the 4-bit counter instance
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("rst_clears_stall", {16'd0, stall_cnt}, 32'd0);
        chk("sat_rst", {28'd0, sat_stall}, 32'd0);
        wb_en_in = 1'b1; mem_r_en_in = 1'b0; alu_result_in = 32'h77; dest_in = 4'd7;
        sat_valid = 1'b1;
        tick();
        sat_valid = 1'b0;
        repeat (10) tick();
        chk("sat_count10", {28'd0, sat_stall}, 32'd10);
        repeat (10) tick();
        chk("sat_count15", {28'd0, sat_stall}, 32'd15);
        chk("sat_head", sat_alu, 32'h77);
        sat_ready = 1'b1;
        tick();
        chk("sat_drained", {31'd0, sat_out_valid}, 32'd0);
        chk("sat_hold", {28'd0, sat_stall}, 32'd15);

        tick();
        chk("sb_empty", sb.size(), 32'd0);
        chk("pop_count", n_pops, 32'd12);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
